// File: rtl/cdc_event_recorder.sv
`default_nettype none
// ============================================================================
//  Module   : cdc_event_recorder
//  Purpose  : Glitch-filters a synchronised level, timestamps accepted edges
//             and queues {direction, timestamp} records for a valid/ready reader.
//  Revision : 1.0  initial release
// ============================================================================
module cdc_event_recorder #(
   parameter int FILT_CYCLES = 2,
   parameter int TS_W        = 8,
   parameter int CNT_W       = 8,
   parameter int DEPTH       = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sync_in,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic             evt_rise,
   output logic [TS_W-1:0]  evt_ts,
   output logic [CNT_W-1:0] evt_count,
   output logic             overflow,
   output logic [CNT_W-1:0] drop_cnt
);

   localparam int         AW     = $clog2(DEPTH);
   localparam logic [3:0] c_FILT = 4'(FILT_CYCLES);

   typedef enum logic [0:0] {
      ST_STABLE = 1'b0,
      ST_CHECK  = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [3:0]        r_run;
   logic [3:0]        w_run_nxt;
   logic              r_filt;
   logic              w_accept;
   logic              w_diff;
   logic [TS_W-1:0]   r_ts;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  r_drop;
   logic              r_ovf;

   logic [TS_W:0]     r_mem [DEPTH];
   logic [AW:0]       r_wr;
   logic [AW:0]       r_rd;
   logic              w_empty;
   logic              w_full;
   logic              w_pop;
   logic              w_push;
   logic              w_drop;

   assign w_diff = (sync_in != r_filt);

   // Filter: an edge is accepted once FILT_CYCLES consecutive enabled samples differ from filt
   always_comb begin
      w_state_nxt = r_state;
      w_run_nxt   = r_run;
      w_accept    = 1'b0;
      case (r_state)
         ST_STABLE: begin
            if (en && w_diff) begin
               w_run_nxt = 4'd1;
               if (FILT_CYCLES == 1) begin
                  w_accept = 1'b1;
               end else begin
                  w_state_nxt = ST_CHECK;
               end
            end
         end
         ST_CHECK: begin
            if (!en || !w_diff) begin
               w_state_nxt = ST_STABLE;
            end else begin
               w_run_nxt = r_run + 4'd1;
               if (w_run_nxt == c_FILT) begin
                  w_accept    = 1'b1;
                  w_state_nxt = ST_STABLE;
               end
            end
         end
         default: w_state_nxt = ST_STABLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_STABLE;
         r_run   <= '0;
         r_filt  <= 1'b0;
         r_ts    <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_run   <= w_run_nxt;
         if (w_accept) begin
            r_filt <= ~r_filt;
            if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
         end
         if (en) r_ts <= r_ts + 1'b1;
      end
   end

   // Record FIFO; the extra pointer bit separates full from empty
   assign w_empty = (r_wr == r_rd);
   assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign w_pop   = !w_empty && evt_ready;
   assign w_push  = w_accept && (!w_full || w_pop);
   assign w_drop  = w_accept && w_full && !w_pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr   <= '0;
         r_rd   <= '0;
         r_ovf  <= 1'b0;
         r_drop <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr[AW-1:0]] <= {~r_filt, r_ts};
            r_wr                <= r_wr + 1'b1;
         end
         if (w_pop) r_rd <= r_rd + 1'b1;
         if (w_drop) begin
            r_ovf <= 1'b1;
            if (r_drop != '1) r_drop <= r_drop + 1'b1;
         end
      end
   end

   assign evt_valid          = !w_empty;
   assign {evt_rise, evt_ts} = r_mem[r_rd[AW-1:0]];
   assign evt_count          = r_cnt;
   assign overflow           = r_ovf;
   assign drop_cnt           = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_cdc_event_recorder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cdc_event_recorder
//  Purpose  : Self-checking bench for cdc_event_recorder against a queue-based
//             reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cdc_event_recorder;

   localparam int FILT = 2;
   localparam int TSW  = 4;
   localparam int CNTW = 4;
   localparam int DEP  = 4;
   localparam int CMAX = (1 << CNTW) - 1;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            en;
   logic            sync_in;
   logic            evt_valid;
   logic            evt_ready;
   logic            evt_rise;
   logic [TSW-1:0]  evt_ts;
   logic [CNTW-1:0] evt_count;
   logic            overflow;
   logic [CNTW-1:0] drop_cnt;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   bit            m_filt;
   int            m_streak;
   int            m_ts;
   int            m_cnt;
   bit            m_ovf;
   int            m_drop;
   logic [TSW:0]  mq[$];

   cdc_event_recorder #(
      .FILT_CYCLES(FILT), .TS_W(TSW), .CNT_W(CNTW), .DEPTH(DEP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .sync_in(sync_in),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_rise(evt_rise),
      .evt_ts(evt_ts), .evt_count(evt_count), .overflow(overflow),
      .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_filt = 0; m_streak = 0; m_ts = 0; m_cnt = 0; m_ovf = 0; m_drop = 0;
      mq.delete();
   endtask

   // One clock of the behavioural rules, using the inputs present at the edge
   task automatic model_step();
      bit           pop;
      bit           acc;
      logic [TSW:0] rec;
      pop = (mq.size() > 0) && (evt_ready === 1'b1);
      acc = 0;
      if (en && (sync_in !== m_filt)) begin
         m_streak++;
         if (m_streak == FILT) begin
            acc = 1;
            m_streak = 0;
         end
      end else begin
         m_streak = 0;
      end
      rec = {~m_filt, TSW'(m_ts)};
      if (pop) void'(mq.pop_front());
      if (acc) begin
         if (mq.size() < DEP) mq.push_back(rec);
         else begin
            m_ovf = 1;
            if (m_drop < CMAX) m_drop++;
         end
         m_filt = ~m_filt;
         if (m_cnt < CMAX) m_cnt++;
      end
      if (en) m_ts = (m_ts + 1) % (1 << TSW);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic toggle_edge();
      sync_in = ~sync_in;
      ticks(3);
   endtask

   task automatic test_reset();
      #1;
      n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", evt_valid); end
      n_cmp++; if (evt_count !== '0) begin n_err++; $display("FAIL reset_count: got %0d want 0", evt_count); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", overflow); end
      n_cmp++; if (drop_cnt !== '0) begin n_err++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
      n_cmp++; if ({evt_rise, evt_ts} !== '0) begin n_err++; $display("FAIL reset_head: got %0h want 0", {evt_rise, evt_ts}); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_single_edge();
      en = 1'b1; sync_in = 1'b0; evt_ready = 1'b0;
      ticks(2);
      sync_in = 1'b1;
      tick();
      n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL edge_early_valid: got %b want 0", evt_valid); end
      tick();
      n_cmp++; if (evt_valid !== 1'b1) begin n_err++; $display("FAIL edge_valid: got %b want 1", evt_valid); end
      n_cmp++; if (evt_rise !== 1'b1) begin n_err++; $display("FAIL edge_rise: got %b want 1", evt_rise); end
      n_cmp++; if (evt_ts !== 4'd3) begin n_err++; $display("FAIL edge_ts: got %0d want 3", evt_ts); end
      n_cmp++; if (evt_count !== 4'd1) begin n_err++; $display("FAIL edge_count: got %0d want 1", evt_count); end
      ticks(3);
      n_cmp++; if (evt_count !== 4'd1 || evt_ts !== 4'd3) begin n_err++; $display("FAIL edge_hold: got cnt=%0d ts=%0d want cnt=1 ts=3", evt_count, evt_ts); end
   endtask

   task automatic test_glitch();
      evt_ready = 1'b1;
      sync_in = 1'b0;
      ticks(4);
      n_cmp++; if (evt_count !== 4'd2) begin n_err++; $display("FAIL fall_count: got %0d want 2", evt_count); end
      sync_in = 1'b1;
      tick();
      sync_in = 1'b0;
      ticks(4);
      n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL glitch_valid: got %b want 0", evt_valid); end
      n_cmp++; if (evt_count !== 4'd2) begin n_err++; $display("FAIL glitch_count: got %0d want 2", evt_count); end
      n_cmp++; if (int'(evt_count) != m_cnt) begin n_err++; $display("FAIL glitch_model_count: got %0d want %0d", evt_count, m_cnt); end
   endtask

   task automatic test_overflow();
      int prev;
      evt_ready = 1'b0;
      for (int i = 0; i < 6; i++) toggle_edge();
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", overflow); end
      n_cmp++; if (drop_cnt !== 4'd2) begin n_err++; $display("FAIL ovf_drop: got %0d want 2", drop_cnt); end
      n_cmp++; if (evt_count !== 4'd8) begin n_err++; $display("FAIL ovf_count: got %0d want 8", evt_count); end
      evt_ready = 1'b1;
      prev = 0;
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (evt_valid !== 1'b1 || evt_rise !== ((i % 2) == 0)) begin n_err++; $display("FAIL ovf_rise%0d: got v=%b r=%b want v=1 r=%b", i, evt_valid, evt_rise, (i % 2) == 0); end
         n_cmp++; if ({evt_rise, evt_ts} !== mq[0]) begin n_err++; $display("FAIL ovf_head%0d: got %0h want %0h", i, {evt_rise, evt_ts}, mq[0]); end
         if (i > 0) begin
            n_cmp++; if (((int'(evt_ts) - prev + 16) % 16) != 3) begin n_err++; $display("FAIL ovf_ts_step%0d: got %0d after %0d want step 3", i, evt_ts, prev); end
         end
         prev = int'(evt_ts);
         tick();
      end
      n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL ovf_drained: got %b want 0", evt_valid); end
   endtask

   task automatic test_full_pop();
      logic [TSW:0] last;
      evt_ready = 1'b0;
      for (int i = 0; i < 4; i++) toggle_edge();
      sync_in = ~sync_in;
      tick();
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      last = mq[mq.size() - 1];
      n_cmp++; if (drop_cnt !== 4'd2) begin n_err++; $display("FAIL fullpop_drop: got %0d want 2", drop_cnt); end
      n_cmp++; if (mq.size() != 4 || last[TSW] !== 1'b1) begin n_err++; $display("FAIL fullpop_model: got size=%0d rise=%b want 4/1", mq.size(), last[TSW]); end
      evt_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (evt_valid !== 1'b1 || {evt_rise, evt_ts} !== mq[0]) begin n_err++; $display("FAIL fullpop_head%0d: got v=%b %0h want %0h", i, evt_valid, {evt_rise, evt_ts}, mq[0]); end
         tick();
      end
      n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL fullpop_drained: got %b want 0", evt_valid); end
   endtask

   task automatic test_en_low();
      int cnt0;
      evt_ready = 1'b0;
      toggle_edge();
      toggle_edge();
      cnt0 = int'(evt_count);
      sync_in = ~sync_in;
      tick();
      en = 1'b0;
      evt_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         n_cmp++; if (evt_valid !== 1'b1 || {evt_rise, evt_ts} !== mq[0]) begin n_err++; $display("FAIL enlow_drain%0d: got v=%b %0h want %0h", i, evt_valid, {evt_rise, evt_ts}, mq[0]); end
         tick();
      end
      ticks(5);
      n_cmp++; if (evt_valid !== 1'b0 || int'(evt_count) != cnt0) begin n_err++; $display("FAIL enlow_noevt: got v=%b cnt=%0d want 0/%0d", evt_valid, evt_count, cnt0); end
      en = 1'b1;
      evt_ready = 1'b0;
      ticks(2);
      n_cmp++; if (evt_valid !== 1'b1 || {evt_rise, evt_ts} !== mq[0]) begin n_err++; $display("FAIL enlow_resume: got v=%b %0h want %0h", evt_valid, {evt_rise, evt_ts}, mq[0]); end
      evt_ready = 1'b1;
      ticks(20);
      toggle_edge();
      n_cmp++; if (evt_valid !== 1'b0 || int'(evt_count) != m_cnt) begin n_err++; $display("FAIL wrap_cnt: got v=%b cnt=%0d want 0/%0d", evt_valid, evt_count, m_cnt); end
      evt_ready = 1'b0;
      toggle_edge();
      n_cmp++; if ({evt_rise, evt_ts} !== mq[0]) begin n_err++; $display("FAIL wrap_ts: got %0h want %0h", {evt_rise, evt_ts}, mq[0]); end
      evt_ready = 1'b1;
      ticks(2);
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         en = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 2) == 0) sync_in = ~sync_in;
         evt_ready = ($urandom_range(0, 3) == 0);
         tick();
         n_cmp++; if (evt_valid !== (mq.size() > 0)) begin n_err++; $display("FAIL rnd_valid@%0d: got %b want %b", c, evt_valid, mq.size() > 0); end
         if (mq.size() > 0) begin
            n_cmp++; if ({evt_rise, evt_ts} !== mq[0]) begin n_err++; $display("FAIL rnd_head@%0d: got %0h want %0h", c, {evt_rise, evt_ts}, mq[0]); end
         end
         n_cmp++; if (int'(evt_count) != m_cnt || int'(drop_cnt) != m_drop || overflow !== m_ovf) begin
            n_err++; $display("FAIL rnd_stats@%0d: got cnt=%0d drop=%0d ovf=%b want %0d/%0d/%b", c, evt_count, drop_cnt, overflow, m_cnt, m_drop, m_ovf);
         end
      end
   endtask

   task automatic test_reset_midop();
      en = 1'b1;
      evt_ready = 1'b0;
      for (int i = 0; i < 3; i++) toggle_edge();
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", evt_valid); end
      n_cmp++; if (evt_count !== '0 || drop_cnt !== '0 || overflow !== 1'b0) begin n_err++; $display("FAIL rst_stats: got cnt=%0d drop=%0d ovf=%b want 0", evt_count, drop_cnt, overflow); end
      sync_in = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      sync_in = 1'b1;
      ticks(2);
      n_cmp++; if (evt_valid !== 1'b1 || evt_rise !== 1'b1 || evt_ts !== 4'd1) begin n_err++; $display("FAIL rst_first: got v=%b r=%b ts=%0d want 1/1/1", evt_valid, evt_rise, evt_ts); end
      n_cmp++; if (evt_count !== 4'd1) begin n_err++; $display("FAIL rst_count: got %0d want 1", evt_count); end
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; sync_in = 1'b0; evt_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      test_reset();
      test_single_edge();
      test_glitch();
      test_overflow();
      test_full_pop();
      test_en_low();
      test_random();
      test_reset_midop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
